// File: rtl/snake_pkg.sv
// Shared constants, encodings and helpers for the snake body mover.
package snake_pkg;
   localparam int SEG_W   = 8;
   localparam int COORD_W = 4;
   localparam int MAX_LEN = 225;
   localparam int LEN_W   = 8;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   localparam logic [COORD_W-1:0] RST_Y      = 4'd8;
   localparam logic [COORD_W-1:0] RST_HEAD_X = 4'd8;
   localparam logic [COORD_W-1:0] RST_NECK_X = 4'd7;
   localparam logic [COORD_W-1:0] RST_TAIL_X = 4'd6;
   localparam logic [LEN_W-1:0]   RST_LEN    = 8'd3;
   localparam dir_t               RST_DIR    = DIR_RIGHT;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      CHECK,
      SHIFT,
      NOTIFY,
      DEAD
   } state_t;

   // Opposite directions differ only in the upper encoding bit.
   function automatic dir_t reverse_dir(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

   function automatic logic [SEG_W-1:0] next_cell(input logic [SEG_W-1:0] seg, input dir_t d);
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      x = seg[COORD_W-1:0];
      y = seg[SEG_W-1:COORD_W];
      case (d)
         DIR_UP:    y = y - COORD_W'(1);
         DIR_RIGHT: x = x + COORD_W'(1);
         DIR_DOWN:  y = y + COORD_W'(1);
         default:   x = x - COORD_W'(1);
      endcase
      return {y, x};
   endfunction
endpackage

// File: rtl/snake_collide.sv
// Parallel self-collision detector: flags a match between the candidate head
// and any of the first `count` packed body segments.
module snake_collide #(
   parameter int MAX_LEN = 225,
   parameter int COORD_W = 4
) (
   input  logic [2*COORD_W-1:0]         head,
   input  logic [2*COORD_W*MAX_LEN-1:0] body,
   input  logic [7:0]                   count,
   output logic                         hit
);
   import snake_pkg::*;

   localparam int SW = 2*COORD_W;

   logic [MAX_LEN-1:0] match;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
         assign match[gi] = (body[gi*SW +: SW] == head) && (8'(gi) < count);
      end
   endgenerate

   assign hit = |match;
endmodule

// File: rtl/snake_body.sv
// Snake body register file and per-tick mover: direction latch, head advance,
// body shift with optional growth, self-collision detection and write strobe.
module snake_body #(
   parameter int MAX_LEN = snake_pkg::MAX_LEN,
   parameter int COORD_W = snake_pkg::COORD_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         step,
   input  logic [1:0]                   dir_in,
   input  logic                         grow,
   output logic [2*COORD_W*MAX_LEN-1:0] snake_in,
   output logic [7:0]                   length,
   output logic [COORD_W-1:0]           head_x,
   output logic [COORD_W-1:0]           head_y,
   output logic                         readSnake,
   output logic                         busy,
   output logic                         dead
);
   import snake_pkg::*;

   localparam int         SW        = 2*COORD_W;
   localparam logic [7:0] MAX_LEN_L = 8'(MAX_LEN);

   state_t                     state_reg, state_next;
   dir_t                       dir_reg, dir_next;
   logic [SW-1:0]              nh_reg, nh_next;
   logic [MAX_LEN-1:0][SW-1:0] body_reg, body_next;
   logic [SW-1:0]              body_rst [MAX_LEN];
   logic [SW-1:0]              shifted  [MAX_LEN];
   logic [7:0]                 len_reg, len_next;
   logic                       grow_pending_reg, grow_pending_next;
   logic                       grow_apply;
   logic [7:0]                 len_grown;
   logic [7:0]                 cmp_count;
   logic [SW-1:0]              tail_new;
   logic                       hit;

   // When growing, the tail stays put and must be part of the collision set.
   assign grow_apply = grow_pending_reg && (len_reg < MAX_LEN_L);
   assign len_grown  = grow_apply ? len_reg + 8'd1 : len_reg;
   assign cmp_count  = grow_apply ? len_reg : len_reg - 8'd1;
   assign tail_new   = body_reg[len_grown - 8'd2];

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
         if (gi == 0) begin : g_head
            assign shifted[gi]  = nh_reg;
            assign body_rst[gi] = {RST_Y, RST_HEAD_X};
         end else begin : g_body
            // Slots past the new length copy the new tail so they stay harmless.
            assign shifted[gi]  = (8'(gi) < len_grown) ? body_reg[gi-1] : tail_new;
            assign body_rst[gi] = {RST_Y, (gi == 1) ? RST_NECK_X : RST_TAIL_X};
         end
      end
   endgenerate

   snake_collide #(
      .MAX_LEN(MAX_LEN),
      .COORD_W(COORD_W)
   ) u_collide (
      .head (nh_reg),
      .body (body_reg),
      .count(cmp_count),
      .hit  (hit)
   );

   always_comb begin
      state_next        = state_reg;
      dir_next          = dir_reg;
      nh_next           = nh_reg;
      len_next          = len_reg;
      body_next         = body_reg;
      grow_pending_next = grow_pending_reg | grow;
      unique case (state_reg)
         IDLE: begin
            if (step) state_next = CALC;
         end
         CALC: begin
            if (dir_t'(dir_in) != reverse_dir(dir_reg)) dir_next = dir_t'(dir_in);
            nh_next    = next_cell(body_reg[0], dir_next);
            state_next = CHECK;
         end
         CHECK: begin
            state_next = hit ? DEAD : SHIFT;
         end
         SHIFT: begin
            for (int k = 0; k < MAX_LEN; k++) body_next[k] = shifted[k];
            len_next          = len_grown;
            grow_pending_next = grow;
            state_next        = NOTIFY;
         end
         NOTIFY: begin
            state_next = IDLE;
         end
         DEAD: begin
            grow_pending_next = grow_pending_reg;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         dir_reg          <= RST_DIR;
         nh_reg           <= {RST_Y, RST_HEAD_X};
         len_reg          <= RST_LEN;
         grow_pending_reg <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++) body_reg[k] <= body_rst[k];
      end else begin
         state_reg        <= state_next;
         dir_reg          <= dir_next;
         nh_reg           <= nh_next;
         len_reg          <= len_next;
         grow_pending_reg <= grow_pending_next;
         body_reg         <= body_next;
      end
   end

   assign snake_in  = body_reg;
   assign length    = len_reg;
   assign head_x    = body_reg[0][COORD_W-1:0];
   assign head_y    = body_reg[0][SW-1:COORD_W];
   assign readSnake = (state_reg != NOTIFY);
   assign busy      = (state_reg != IDLE) && (state_reg != DEAD);
   assign dead      = (state_reg == DEAD);
endmodule

// File: tb/tb_snake_body.sv
// Randomized and directed bench for snake_body against a queue-based model
// of the snake (head-first coordinate lists).
module tb_snake_body;
   localparam int ML = 225;
   localparam int VW = 8*ML;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          step   = 1'b0;
   logic          grow   = 1'b0;
   logic [1:0]    dir_in = 2'b01;
   logic [VW-1:0] snake_in;
   logic [7:0]    length;
   logic [3:0]    head_x;
   logic [3:0]    head_y;
   logic          readSnake;
   logic          busy;
   logic          dead;

   int checks = 0;
   int errors = 0;

   int mx[$];
   int my[$];
   int m_dir;
   bit m_grow;
   bit m_dead;

   always #5 clk = ~clk;

   snake_body #(
      .MAX_LEN(ML),
      .COORD_W(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .step     (step),
      .dir_in   (dir_in),
      .grow     (grow),
      .snake_in (snake_in),
      .length   (length),
      .head_x   (head_x),
      .head_y   (head_y),
      .readSnake(readSnake),
      .busy     (busy),
      .dead     (dead)
   );

   task automatic m_reset();
      mx = {8, 7, 6};
      my = {8, 8, 8};
      m_dir  = 1;
      m_grow = 0;
      m_dead = 0;
   endtask

   task automatic m_step(input int d, input bit grow_at_shift);
      int nx, ny, n;
      bit apply, hit;
      if (m_dead) return;
      if (d != (m_dir + 2) % 4) m_dir = d;
      nx = mx[0];
      ny = my[0];
      case (m_dir)
         0:       ny = (ny + 15) % 16;
         1:       nx = (nx + 1) % 16;
         2:       ny = (ny + 1) % 16;
         default: nx = (nx + 15) % 16;
      endcase
      apply = m_grow && (mx.size() < ML);
      n = apply ? mx.size() : mx.size() - 1;
      hit = 0;
      for (int k = 0; k < n; k++) if (mx[k] == nx && my[k] == ny) hit = 1;
      if (hit) begin
         m_dead = 1;
         return;
      end
      mx.push_front(nx);
      my.push_front(ny);
      if (!apply) begin
         void'(mx.pop_back());
         void'(my.pop_back());
      end
      m_grow = grow_at_shift;
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [VW-1:0] v;
      int idx;
      v = '0;
      for (int k = 0; k < ML; k++) begin
         idx = (k < mx.size()) ? k : mx.size() - 1;
         v[8*k +: 8] = {4'(my[idx]), 4'(mx[idx])};
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_body(input string tag);
      logic [VW-1:0] e;
      int bad;
      e = model_vec();
      bad = 0;
      checks++;
      assert (snake_in === e) else begin
         errors++;
         for (int k = ML - 1; k >= 0; k--) if (snake_in[8*k +: 8] !== e[8*k +: 8]) bad = k;
         $error("FAIL %s segment %0d observed %0h expected %0h", tag, bad, snake_in[8*bad +: 8], e[8*bad +: 8]);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_head_x"}, head_x, mx[0]);
      chk({tag, "_head_y"}, head_y, my[0]);
      chk({tag, "_length"}, length, mx.size());
      chk({tag, "_dead"}, dead, m_dead);
      chk_body({tag, "_body"});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      chk_state("reset");
      chk("reset_busy", busy, 0);
      chk("reset_read", readSnake, 1);
   endtask

   task automatic grow_pulse();
      grow = 1'b1;
      @(posedge clk); #1;
      grow = 1'b0;
      if (!m_dead) m_grow = 1;
   endtask

   // One game tick; optionally a second step while busy and a grow during SHIFT.
   task automatic do_step(input int d, input bit extra, input bit grow_shift);
      int cyc, late;
      bit strobe, died, was_dead;
      was_dead = m_dead;
      dir_in = 2'(d);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      cyc = 0;
      strobe = 0;
      died = 0;
      while (!strobe && !(died && !was_dead) && cyc < 8) begin
         if (extra && cyc == 0) step = 1'b1;
         if (grow_shift && cyc == 2) grow = 1'b1;
         @(posedge clk); #1;
         step = 1'b0;
         grow = 1'b0;
         cyc++;
         if (readSnake === 1'b0) strobe = 1;
         if (dead === 1'b1) died = 1;
      end
      m_step(d, grow_shift);
      if (was_dead) begin
         chk("ignored_step_strobe", strobe, 0);
      end else if (m_dead) begin
         chk("dead_cycle", cyc, 2);
         chk("dead_no_strobe", strobe, 0);
      end else begin
         chk("strobe_cycle", cyc, 3);
      end
      chk_state("step");
      late = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (readSnake !== 1'b1) late++;
      end
      chk("extra_strobes", late, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      int n, s;
      do_reset();

      // Basic move, reversal rejection, x wrap, y wrap.
      do_step(1, 0, 0);
      do_step(3, 0, 0);
      repeat (5) do_step(1, 0, 0);
      do_step(1, 0, 0);
      repeat (9) do_step(0, 0, 0);

      // Growth, and growth re-armed by a grow coincident with SHIFT.
      grow_pulse();
      do_step(1, 0, 0);
      grow_pulse();
      do_step(1, 0, 1);
      do_step(1, 0, 0);
      do_step(1, 1, 0);

      // Randomized ticks.
      repeat (60) begin
         if ($urandom_range(0, 3) == 0) grow_pulse();
         do_step(int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         if (m_dead) begin
            do_step(1, 0, 0);
            do_reset();
         end
      end

      // Self-collision with length 5: up, left, down.
      do_reset();
      grow_pulse();
      do_step(1, 0, 0);
      grow_pulse();
      do_step(1, 0, 0);
      do_step(0, 0, 0);
      do_step(3, 0, 0);
      do_step(2, 0, 0);
      chk("collide_model_dead", m_dead, 1);
      do_step(1, 1, 0);
      do_step(2, 0, 0);
      do_reset();

      // Grow to the maximum length along a torus-covering helix.
      s = 0;
      while (mx.size() < ML && !m_dead && s < 260) begin
         grow_pulse();
         do_step((s % 16 == 0) ? 2 : 1, 0, 0);
         s++;
      end
      chk("max_len_reached", length, ML);
      grow_pulse();
      do_step((s % 16 == 0) ? 2 : 1, 0, 0);
      s++;
      do_step((s % 16 == 0) ? 2 : 1, 0, 0);

      // Reset during CHECK cancels the strobe and any pending growth.
      do_reset();
      grow_pulse();
      dir_in = 2'b01;
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      @(posedge clk); #1;
      chk("busy_in_check", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      n = 0;
      repeat (5) begin
         if (readSnake !== 1'b1) n++;
         @(posedge clk); #1;
      end
      chk("rst_mid_no_strobe", n, 0);
      chk_state("rst_mid");
      do_step(1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/snake_body.md
# snake_body

Snake body state holder and mover for the 16×16 game grid. On each game-tick `step` it does the following: accepts a direction, advances the head one cell, shifts the body, applies pending growth and checks for self-collision. It drives the packed 1800-bit segment vector and the `readSnake` write strobe consumed by the downstream snake grid writer. It sits between the input/tick logic and the grid-writer stage.

## Interface
Parameters:
- `MAX_LEN`, 225: maximum segment count; packed vector width is 8×`MAX_LEN` = 1800.
- `COORD_W`, 4: coordinate width; grid is 2^`COORD_W` per axis.

Ports:
- `clk`, input, 1: single clock; everything is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `step`, input, 1: game-tick pulse. Sampled only in IDLE.
- `dir_in`, input, 2: requested direction.
  - 00: up, y−1.
  - 01: right, x+1.
  - 10: down, y+1.
  - 11: left, x−1.
- `grow`, input, 1: one-cycle pulse that requests one segment of growth.
- `snake_in`, output, 1800: packed segments, 8 bits each, segment 0 = head.
  - Bits [8k+3:8k] = x of segment k.
  - Bits [8k+7:8k+4] = y of segment k.
- `length`, output, 8: current segment count, range 3..`MAX_LEN`.
- `head_x`, `head_y`, output, 4 each: head coordinates, same as segment 0.
- `readSnake`, output, 1: 1 = hold/read; 0 for exactly one cycle = downstream writer must write `snake_in`.
- `busy`, output, 1: high in any state other than IDLE or DEAD.
- `dead`, output, 1: self-collision occurred; sticky until `rst`.

## Operation
- Reset values:
  - Segment 0 = (8,8), segment 1 = (7,8), segment 2 = (6,8).
  - Segments 3..224 = copy of the tail, (6,8).
  - `length`=3; latched direction = right (01).
  - `grow_pending`=0, `readSnake`=1, `busy`=0, `dead`=0; state IDLE.
- Unused segments (index ≥ `length`) always mirror the current tail, so downstream writes of them are harmless.
- FSM:
  - IDLE → CALC on `step`.
  - CALC → CHECK → SHIFT → NOTIFY → IDLE.
  - CHECK → DEAD on collision.
  - DEAD is absorbing; only `rst` leaves it.
- CALC:
  - Latch `dir_in`, unless it is the exact reverse of the latched direction; in that case keep the old direction.
  - Compute the next head with modulo-16 wrap: x=15 moving right gives x=0; y=0 moving up gives y=15.
- CHECK:
  - Compare the next head in parallel against segments 0..`length`−2.
  - If `grow_pending` and `length`<`MAX_LEN`, compare against 0..`length`−1 instead, because the tail is not vacated.
  - Any match → DEAD. In that case the body, `length` and `readSnake` are unchanged.
- SHIFT:
  - Segment k ← segment k−1 for k ≥ 1; segment 0 ← next head.
  - If `grow_pending` and `length`<`MAX_LEN`: `length`+1.
  - `grow_pending` clears in every case; at `MAX_LEN` the growth is discarded.
  - Unused segments are refreshed to the new tail.
- NOTIFY: `readSnake`=0 for this single cycle.
- `grow` can be captured in any state except DEAD and sets `grow_pending`. A `grow` in the same cycle that SHIFT clears the flag re-sets it for the next step.
- `step` outside IDLE is ignored; it is not queued.

## Timing
- `step` is sampled high at edge t0. Then:
  - CALC during t0→t1.
  - CHECK during t1→t2.
  - SHIFT registers update at edge t3.
  - `readSnake`=0 during t3→t4; `snake_in`, `length` and `head_*` are already stable and hold through the strobe.
- Step-to-strobe latency: 3 cycles. The next `step` is accepted from edge t4.
- Collision: `dead` rises at edge t2 and `busy` falls at the same edge; no strobe is issued.
- `rst` in any state, including mid-sequence or DEAD: restores all reset values at the next edge. A pending strobe is cancelled.

## Structure
- Package `snake_pkg`:
  - Constants `SEG_W`=8, `COORD_W`=4, `MAX_LEN`=225.
  - Direction encodings.
  - Reset head/body coordinates and reset length 3.
  - FSM state enum: IDLE, CALC, CHECK, SHIFT, NOTIFY, DEAD.
- Sub-module `snake_collide`: combinational. Takes next head, packed body, compare count; outputs hit. Kept separate for unit testing.

## Test plan
- Reset, then 1 `step` with `dir_in`=01 → strobe 3 cycles later; head (9,8); segments (8,8),(7,8); `length`=3; segment 3 = (7,8).
- Head at (15,8) moving right, 1 `step` → head (0,8), no `dead`. Head at (x,0) moving up → y=15.
- Latched dir right, `dir_in`=11 at `step` → reversal ignored, head x+1.
- `grow` pulse, then `step` → `length` 3→4; segment 3 = old tail (6,8). `grow` coincident with SHIFT → `length` grows again on the following step.
- Length 5, steer into own body via up, left, down → `dead`=1 at t2, no strobe, `snake_in` frozen. Later `step`s ignored; `rst` restores (8,8), `length`=3.
- `length`=225 plus `grow` → `length` stays 225. `step` while `busy` → ignored, exactly one strobe. `rst` during CHECK → no strobe, reset values.
